// File: rtl/imem_loader_if.sv
// Byte-stream handshake into the instruction-memory loader.
// The image source uses master; the loader uses slave.
interface imem_loader_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       load_last;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, output load_last, input byte_ready);
  modport slave  (input byte_valid, input byte_data, input load_last, output byte_ready);
endinterface

// File: rtl/imem_loader.sv
// Program-image loader and instruction RAM: clears RAM to NOP, assembles little-endian
// words from a byte stream, then serves instructions asynchronously once loading succeeds.
module imem_loader #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.slave      bus,
  input  logic [63:0]       pc,
  output logic [31:0]       instruction,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [31:0]   NOP  = 32'h0000_0013;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {CLEAR, LOAD, DONE, ERROR} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W:0]     wr_ptr, wr_ptr_nxt;
  logic [1:0]          lane, lane_nxt;
  logic [ADDR_W-1:0]   clr_idx, clr_idx_nxt;
  logic [23:0]         asm_q, asm_nxt;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [31:0]         mem_wdata;
  logic [31:0]         mem [DEPTH];

  logic                pc_unused;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      wr_ptr  <= '0;
      lane    <= '0;
      clr_idx <= '0;
      asm_q   <= '0;
    end else begin
      state   <= state_nxt;
      wr_ptr  <= wr_ptr_nxt;
      lane    <= lane_nxt;
      clr_idx <= clr_idx_nxt;
      asm_q   <= asm_nxt;
    end
  end

  // RAM has no reset of its own; the CLEAR sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    lane_nxt    = lane;
    clr_idx_nxt = clr_idx;
    asm_nxt     = asm_q;
    mem_we      = 1'b0;
    mem_addr    = wr_ptr[ADDR_W-1:0];
    mem_wdata   = {bus.byte_data, asm_q};

    case (state)
      CLEAR: begin
        mem_we      = !reset;
        mem_addr    = clr_idx;
        mem_wdata   = NOP;
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_idx == '1) state_nxt = LOAD;
      end
      LOAD: begin
        if (bus.byte_valid) begin
          if (wr_ptr == FULL) begin
            state_nxt = ERROR;
          end else if (lane == 2'd3) begin
            mem_we     = !reset;
            wr_ptr_nxt = wr_ptr + 1'b1;
            lane_nxt   = '0;
            if (bus.load_last) state_nxt = DONE;
          end else begin
            case (lane)
              2'd0:    asm_nxt[7:0]   = bus.byte_data;
              2'd1:    asm_nxt[15:8]  = bus.byte_data;
              default: asm_nxt[23:16] = bus.byte_data;
            endcase
            lane_nxt = lane + 1'b1;
            if (bus.load_last) state_nxt = ERROR;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.byte_ready = (state == LOAD);
  assign core_reset     = (state != DONE);
  assign load_done      = (state == DONE);
  assign load_error     = (state == ERROR);
  assign word_count     = wr_ptr;

  assign instruction = (state == DONE) ? mem[pc[ADDR_W+1:2]] : NOP;

  // Byte offset and high PC bits are intentionally ignored (addresses alias).
  assign pc_unused = ^{pc[63:ADDR_W+2], pc[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader with a byte-queue reference model.
module tb_imem_loader;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int M_LOAD = 0, M_DONE = 1, M_ERR = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [63:0]       pc;
  logic [31:0]       instruction;
  logic              core_reset, load_done, load_error;
  logic [ADDR_W:0]   word_count;

  imem_loader_if bus();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .pc          (pc),
    .instruction (instruction),
    .core_reset  (core_reset),
    .load_done   (load_done),
    .load_error  (load_error),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: accepted bytes since reset plus load outcome.
  logic [7:0] m_q[$];
  int         m_status;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_status = M_LOAD;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic last);
    if (m_status != M_LOAD) return;
    if (m_q.size() == 4*DEPTH) begin
      m_status = M_ERR;
      return;
    end
    m_q.push_back(b);
    if (last) m_status = (m_q.size() % 4 == 0) ? M_DONE : M_ERR;
  endtask

  function automatic logic [31:0] exp_instr(input logic [63:0] p);
    int idx;
    if (m_status != M_DONE) return NOP;
    idx = int'((p >> 2) % DEPTH);
    if (idx < m_q.size() / 4)
      return {m_q[4*idx+3], m_q[4*idx+2], m_q[4*idx+1], m_q[4*idx]};
    return NOP;
  endfunction

  // {core_reset, load_done, load_error, word_count}
  function automatic logic [ADDR_W+3:0] exp_status();
    return {m_status != M_DONE, m_status == M_DONE, m_status == M_ERR,
            (ADDR_W+1)'(m_q.size() / 4)};
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    bus.byte_valid = 1'b0;
    for (int i = 0; i < gap; i++) tick();
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    bus.load_last  = last;
    tick();
    bus.byte_valid = 1'b0;
    bus.load_last  = 1'b0;
    model_byte(b, last);
  endtask

  task automatic do_reset(input int n, input logic vld);
    reset          = 1'b1;
    bus.byte_valid = vld;
    bus.byte_data  = 8'($urandom);
    for (int i = 0; i < n; i++) tick();
    reset          = 1'b0;
    bus.byte_valid = 1'b0;
    model_reset();
  endtask

  task automatic wait_clear(output int cyc, output bit crst_ok);
    cyc = 0;
    crst_ok = 1'b1;
    while (!bus.byte_ready && cyc < 200) begin
      if (!core_reset || load_done || load_error || word_count != 0) crst_ok = 1'b0;
      cyc++;
      tick();
    end
  endtask

  task automatic read_instr(input logic [63:0] p, output logic [31:0] d);
    @(negedge clk);
    pc = p;
    #1;
    d = instruction;
  endtask

  function automatic logic [63:0] alias_pc(input int idx);
    logic [63:0] p;
    p = {$urandom, $urandom};
    p[ADDR_W+1:2] = ADDR_W'(idx);
    return p;
  endfunction

  task automatic test_reset();
    int cyc; bit ok; logic [31:0] d;
    do_reset(2, 1'b0);
    pc = 64'h0; #1; d = instruction;
    n_cmp++; if (d !== NOP) begin n_bad++; $display("FAIL reset_instr_pc0: got %h expected %h", d, NOP); end
    pc = 64'h3C; #1; d = instruction;
    n_cmp++; if (d !== NOP) begin n_bad++; $display("FAIL reset_instr_pc3c: got %h expected %h", d, NOP); end
    wait_clear(cyc, ok);
    n_cmp++; if (cyc != DEPTH) begin n_bad++; $display("FAIL reset_clear_len: got %0d expected %0d", cyc, DEPTH); end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL reset_clear_outputs: got %0d expected 1", ok); end
    n_cmp++; if ({core_reset, load_done, load_error, word_count} !== {3'b100, 5'd0}) begin
      n_bad++; $display("FAIL reset_status: got %b expected %b", {core_reset, load_done, load_error, word_count}, {3'b100, 5'd0});
    end
  endtask

  task automatic test_load_basic();
    logic [7:0] img [8] = '{8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    logic [63:0] pcs [4] = '{64'h0, 64'h4, 64'h8, 64'h41};
    logic [31:0] exp [4] = '{32'h0050_0093, 32'h00A0_0113, NOP, 32'h0050_0093};
    logic [31:0] d;
    for (int i = 0; i < 8; i++) send_byte(img[i], i == 7, (i == 0) ? 0 : 1);
    n_cmp++; if ({core_reset, load_done, load_error, word_count} !== {3'b010, 5'd2}) begin
      n_bad++; $display("FAIL basic_status: got %b expected %b", {core_reset, load_done, load_error, word_count}, {3'b010, 5'd2});
    end
    for (int i = 0; i < 4; i++) begin
      read_instr(pcs[i], d);
      n_cmp++; if (d !== exp[i]) begin n_bad++; $display("FAIL basic_read pc=%h: got %h expected %h", pcs[i], d, exp[i]); end
    end
  endtask

  task automatic test_done_ignore();
    logic [31:0] d;
    int bad_ready = 0;
    @(negedge clk);
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.byte_data = 8'($urandom);
      bus.load_last = 1'($urandom);
      if (bus.byte_ready !== 1'b0) bad_ready++;
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    bus.load_last  = 1'b0;
    n_cmp++; if (bad_ready != 0) begin n_bad++; $display("FAIL done_ready: got %0d ready cycles expected 0", bad_ready); end
    n_cmp++; if (word_count !== 5'd2) begin n_bad++; $display("FAIL done_wcount: got %0d expected 2", word_count); end
    read_instr(64'h0, d);
    n_cmp++; if (d !== 32'h0050_0093) begin n_bad++; $display("FAIL done_read: got %h expected %h", d, 32'h0050_0093); end
  endtask

  task automatic test_partial_error();
    int cyc; bit ok; logic [31:0] d;
    do_reset(1, 1'b0);
    wait_clear(cyc, ok);
    n_cmp++; if (cyc != DEPTH || !ok) begin n_bad++; $display("FAIL partial_clear: got %0d/%0d expected %0d/1", cyc, ok, DEPTH); end
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), i == 5, 0);
    n_cmp++; if ({core_reset, load_done, load_error, word_count} !== {3'b101, 5'd1}) begin
      n_bad++; $display("FAIL partial_status: got %b expected %b", {core_reset, load_done, load_error, word_count}, {3'b101, 5'd1});
    end
    read_instr(64'h0, d);
    n_cmp++; if (d !== NOP) begin n_bad++; $display("FAIL partial_read: got %h expected %h", d, NOP); end
  endtask

  task automatic test_overflow();
    int cyc; bit ok;
    do_reset(1, 1'b0);
    wait_clear(cyc, ok);
    for (int i = 0; i < 64; i++) send_byte(8'($urandom), 1'b0, int'($urandom_range(0, 1)));
    n_cmp++; if ({core_reset, load_done, load_error, word_count} !== {3'b100, 5'd16}) begin
      n_bad++; $display("FAIL ovf_full: got %b expected %b", {core_reset, load_done, load_error, word_count}, {3'b100, 5'd16});
    end
    send_byte(8'($urandom), 1'b0, 0);
    n_cmp++; if ({core_reset, load_done, load_error, word_count} !== {3'b101, 5'd16}) begin
      n_bad++; $display("FAIL ovf_error: got %b expected %b", {core_reset, load_done, load_error, word_count}, {3'b101, 5'd16});
    end
  endtask

  task automatic test_full_done();
    int cyc; bit ok; logic [31:0] d, e; logic [63:0] p;
    do_reset(1, 1'b0);
    wait_clear(cyc, ok);
    for (int i = 0; i < 64; i++) send_byte(8'($urandom), i == 63, 0);
    n_cmp++; if ({core_reset, load_done, load_error, word_count} !== exp_status()) begin
      n_bad++; $display("FAIL full_status: got %b expected %b", {core_reset, load_done, load_error, word_count}, exp_status());
    end
    e = {m_q[63], m_q[62], m_q[61], m_q[60]};
    read_instr(64'h3C, d);
    n_cmp++; if (d !== e) begin n_bad++; $display("FAIL full_word15: got %h expected %h", d, e); end
    for (int a = 0; a < DEPTH; a++) begin
      p = alias_pc(a);
      read_instr(p, d);
      n_cmp++; if (d !== exp_instr(p)) begin n_bad++; $display("FAIL full_read pc=%h: got %h expected %h", p, d, exp_instr(p)); end
    end
  endtask

  task automatic test_reset_midload();
    int cyc; bit ok; logic [31:0] d;
    logic [7:0] img [4] = '{8'h13, 8'h00, 8'h00, 8'h00};
    do_reset(1, 1'b0);
    wait_clear(cyc, ok);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, 0);
    do_reset(1, 1'b1);
    n_cmp++; if ({bus.byte_ready, core_reset, word_count} !== {2'b01, 5'd0}) begin
      n_bad++; $display("FAIL mid_reset: got %b expected %b", {bus.byte_ready, core_reset, word_count}, {2'b01, 5'd0});
    end
    wait_clear(cyc, ok);
    n_cmp++; if (cyc != DEPTH || !ok) begin n_bad++; $display("FAIL mid_clear: got %0d/%0d expected %0d/1", cyc, ok, DEPTH); end
    for (int i = 0; i < 4; i++) send_byte(img[i], i == 3, 0);
    n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL mid_done: got %b expected 1", load_done); end
    read_instr(64'h0, d);
    n_cmp++; if (d !== NOP) begin n_bad++; $display("FAIL mid_read0: got %h expected %h", d, NOP); end
    read_instr(64'h4, d);
    n_cmp++; if (d !== NOP) begin n_bad++; $display("FAIL mid_read4: got %h expected %h", d, NOP); end
  endtask

  task automatic test_random();
    int cyc, len, last_at; bit ok; logic [31:0] d; logic [63:0] p;
    for (int it = 0; it < 8; it++) begin
      do_reset(int'($urandom_range(1, 3)), 1'($urandom));
      wait_clear(cyc, ok);
      n_cmp++; if (cyc != DEPTH || !ok) begin n_bad++; $display("FAIL rand_clear it=%0d: got %0d/%0d expected %0d/1", it, cyc, ok, DEPTH); end
      len = int'($urandom_range(1, 68));
      last_at = ($urandom_range(0, 3) == 0) ? len + 1 : int'($urandom_range(1, len));
      if ($urandom_range(0, 1) == 1 && last_at <= len) last_at = last_at - (last_at % 4) + 4;
      for (int i = 1; i <= len; i++) send_byte(8'($urandom), i == last_at, int'($urandom_range(0, 2)));
      n_cmp++; if ({core_reset, load_done, load_error, word_count} !== exp_status()) begin
        n_bad++; $display("FAIL rand_status it=%0d: got %b expected %b", it, {core_reset, load_done, load_error, word_count}, exp_status());
      end
      for (int a = 0; a < DEPTH; a++) begin
        p = alias_pc(a);
        read_instr(p, d);
        n_cmp++; if (d !== exp_instr(p)) begin n_bad++; $display("FAIL rand_read it=%0d pc=%h: got %h expected %h", it, p, d, exp_instr(p)); end
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    pc             = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    bus.load_last  = 1'b0;
    model_reset();
    test_reset();
    test_load_basic();
    test_done_ignore();
    test_partial_error();
    test_overflow();
    test_full_done();
    test_reset_midload();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program-image loader and instruction memory for the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words into an internal instruction RAM. It holds the datapath in reset until a complete image is loaded, then serves `instruction` combinationally from the PC the datapath drives. It sits directly upstream of the datapath's fetch path, and replaces any hard-coded instruction ROM.

## Interface
- `DEPTH`, 256, instruction RAM size in 32-bit words; a power of two, at least 4.
- `ADDR_W`, 8, log2(DEPTH).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_data`  in  8  image byte; the first byte of each word goes to bits [7:0].
- `load_last`  in  1  qualifies the final byte of the image; sampled only on an accepted byte.
- `byte_ready`  out  1  loader can accept a byte.
- `pc`  in  64  fetch address from the datapath (`nextPC`).
- `instruction`  out  32  instruction word at `pc`.
- `core_reset`  out  1  reset to the datapath; high until the image is loaded.
- `load_done`  out  1  image loaded successfully.
- `load_error`  out  1  the load failed.
- `word_count`  out  ADDR_W+1  number of words written so far.

## Operation
- The block has four states: CLEAR, LOAD, DONE and ERROR. All outputs except `instruction` are Moore outputs decoded from the state register.
- **Reset behaviour**
  - `reset` has priority over every other input, including a byte being accepted in the same cycle.
  - Reset sends the block to CLEAR and zeroes the write pointer, byte lane, clear index and assembly register.
  - Values while in reset and in CLEAR: `byte_ready`=0, `core_reset`=1, `load_done`=0, `load_error`=0, `word_count`=0.
- **CLEAR**
  - Each edge with `reset` low writes the NOP word 0x00000013 to mem[clr_idx] and increments clr_idx.
  - The edge that writes index DEPTH-1 moves the block to LOAD.
- **LOAD**
  - `byte_ready`=1. A byte is accepted when `byte_valid && byte_ready`.
  - Each accepted byte is placed in the assembly register at lane `lane` (bits [8*lane+7:8*lane]), and `lane` increments.
  - On lane 3 the full word is written to mem[wr_ptr], `wr_ptr` increments and `lane` returns to 0.
  - Accepted byte with `load_last`=1:
    - if `lane`==3, the word is written and the block goes to DONE;
    - otherwise the partial word is discarded and the block goes to ERROR.
  - Overflow: an accepted byte while `wr_ptr`==DEPTH is discarded and the block goes to ERROR.
  - A `load_last` that completes word DEPTH-1 is legal and goes to DONE.
- **DONE**
  - `byte_ready`=0, `core_reset`=0, `load_done`=1.
  - Input bytes are ignored. The block holds in DONE until reset.
- **ERROR**
  - `byte_ready`=0, `core_reset`=1, `load_error`=1.
  - The block holds in ERROR until reset.
- **`word_count`** always equals `wr_ptr`, which is never cleared except by reset.
- **Instruction read**
  - In DONE, `instruction` = mem[pc[ADDR_W+1:2]].
  - `pc[1:0]` and `pc[63:ADDR_W+2]` are ignored, so upper addresses alias (wrap-around).
  - In every other state `instruction` = 0x00000013.

## Timing
- CLEAR lasts exactly DEPTH cycles after the last cycle in which `reset` is high. `byte_ready` rises in cycle DEPTH+1 after reset deasserts.
- Throughput is one byte per cycle, with no bubbles at word boundaries.
- A word becomes readable at its address in the cycle after the edge that accepts its 4th byte, but is visible on `instruction` only once the block is in DONE.
- If the `load_last` byte is accepted at edge N:
  - `load_done` rises and `core_reset` falls in cycle N+1;
  - the datapath's first active edge is N+1.
- `instruction` has zero cycles of latency from `pc`; the RAM is read asynchronously.
- Reset asserted mid-load or in DONE takes effect at the next edge:
  - `core_reset` returns to 1;
  - the RAM is re-cleared to NOP;
  - any partially assembled word is lost.

## Test plan
1. DEPTH=16, `reset` high for 2 cycles then low -> `byte_ready`=0 for exactly 16 cycles, then 1; `core_reset`=1 throughout; `instruction`=0x00000013 for `pc`=0 and `pc`=0x3C.
2. Bytes 93 00 50 00 13 01 A0 00, with `load_last` on the 8th, fed with `byte_valid` toggling 1,0,1,0 -> `word_count`=2, `load_done`=1 and `core_reset`=0 in the next cycle. Reads: `pc`=0 -> 0x00500093, `pc`=4 -> 0x00A00113, `pc`=8 -> 0x00000013, `pc`=0x41 -> 0x00500093 (alias and misalignment ignored).
3. After test 2, hold `byte_valid`=1 for 10 cycles -> `byte_ready`=0, `word_count` stays 2, and the instruction at `pc`=0 is unchanged.
4. Six bytes with `load_last` on the 6th -> ERROR: `load_error`=1, `word_count`=1, `core_reset`=1, `instruction`=0x00000013.
5. DEPTH=16, 65 bytes with no `load_last` -> `word_count`=16 after byte 64; byte 65 gives `load_error`=1. Repeat with `load_last` on byte 64 -> DONE, and `pc`=0x3C returns word 15.
6. After 5 accepted bytes, assert `reset` for 1 cycle with `byte_valid`=1 -> `word_count`=0 and a 16-cycle CLEAR. Then load 4 bytes 13 00 00 00 with `load_last` -> `pc`=0 gives 0x00000013, `pc`=4 gives 0x00000013, `load_done`=1.
